// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and encodings for the decode-stage register scoreboard.
package reg_scoreboard_pkg;

    // Number of architectural registers; register 0 is hard-wired zero.
    localparam int unsigned NREG     = 32;
    // Register index width.
    localparam int unsigned AW       = 5;
    // Width of the per-register in-flight write counter.
    localparam int unsigned CNT_W    = 2;
    // Cycles after a load issue before its result is forwardable.
    localparam int unsigned LOAD_LAT = 2;
    // Width of the per-register remaining load latency counter.
    localparam int unsigned LD_W     = 2;

    localparam logic [AW-1:0]    REG_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Instruction classes, shared with the register bank.
    typedef enum logic [2:0] {
        load_store,
        alu_inm,
        branch,
        jump_abs,
        alu_reg,
        jump_rel,
        shift_var,
        shift
    } instr_class_e;

    // Register 0 never carries a dependency.
    function automatic logic is_tracked(logic [AW-1:0] idx);
        return idx != REG_ZERO;
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback-facing bus of the register scoreboard.
interface reg_scoreboard_if;
    import reg_scoreboard_pkg::*;

    logic            issue_valid;
    logic [AW-1:0]   issue_rs;
    logic [AW-1:0]   issue_rt;
    logic            issue_use_rs;
    logic            issue_use_rt;
    logic            issue_wr;
    logic [AW-1:0]   issue_rd;
    logic            issue_load;
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic            flush;
    logic            stall;
    logic            issue_ack;
    logic [NREG-1:0] busy_mask;
    logic            err_underflow;

    // Pipeline side: presents instructions and writebacks.
    modport master (
        output issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
        output issue_wr, issue_rd, issue_load, wb_valid, wb_rd, flush,
        input  stall, issue_ack, busy_mask, err_underflow
    );

    // Scoreboard side.
    modport slave (
        input  issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
        input  issue_wr, issue_rd, issue_load, wb_valid, wb_rd, flush,
        output stall, issue_ack, busy_mask, err_underflow
    );

endinterface

// File: rtl/reg_track_entry.sv
// Tracking state of one architectural register: in-flight write count and
// remaining load latency.
module reg_track_entry
    import reg_scoreboard_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,     // flush: drop all tracking
    input  logic             inc_i,       // accepted issue writing this register
    input  logic             dec_i,       // writeback retiring this register
    input  logic             load_i,      // accepted issue is a load
    output logic [CNT_W-1:0] pend_cnt_o,
    output logic [LD_W-1:0]  ld_cnt_o,
    output logic             busy_o,
    output logic             underflow_o
);

    logic [CNT_W-1:0] pend_q, pend_d;
    logic [LD_W-1:0]  ld_q, ld_d;
    logic             busy_q;

    // Pending-write count: issue and writeback together cancel out; never
    // drops below zero.
    always_comb begin
        pend_d = pend_q;
        if (clear_i) begin
            pend_d = '0;
        end else if (inc_i && !dec_i) begin
            pend_d = pend_q + CNT_W'(1);
        end else if (dec_i && !inc_i && pend_q != '0) begin
            pend_d = pend_q - CNT_W'(1);
        end
    end

    // Load latency: reload on a load issue, otherwise count down to zero.
    always_comb begin
        ld_d = ld_q;
        if (clear_i) begin
            ld_d = '0;
        end else if (load_i) begin
            ld_d = LD_W'(LOAD_LAT);
        end else if (ld_q != '0) begin
            ld_d = ld_q - LD_W'(1);
        end
    end

    // State registers; busy is registered from the next count so it tracks
    // pend_cnt without an extra cycle of lag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pend_q <= '0;
            ld_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ld_q   <= ld_d;
            busy_q <= (pend_d != '0);
        end
    end

    assign pend_cnt_o  = pend_q;
    assign ld_cnt_o    = ld_q;
    assign busy_o      = busy_q;
    assign underflow_o = dec_i && (pend_q == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: holds decode while a source (or the destination) is
// still waiting on a load, or while the destination's write counter is full.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    reg_scoreboard_if.slave bus
);

    logic [NREG-1:0][CNT_W-1:0] pend_cnt;
    logic [NREG-1:0][LD_W-1:0]  ld_cnt;
    logic [NREG-1:0]            busy;
    logic [NREG-1:1]            inc;
    logic [NREG-1:1]            dec;
    logic [NREG-1:1]            load;
    logic [NREG-1:1]            underflow;
    logic                       hazard;
    logic                       stall;
    logic                       ack;
    logic                       err_q;

    // Register 0 is never tracked and always reads as idle.
    assign pend_cnt[0] = '0;
    assign ld_cnt[0]   = '0;
    assign busy[0]     = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        reg_track_entry u_entry (
            .clk_i       (clk),
            .reset_i     (reset),
            .clear_i     (bus.flush),
            .inc_i       (inc[r]),
            .dec_i       (dec[r]),
            .load_i      (load[r]),
            .pend_cnt_o  (pend_cnt[r]),
            .ld_cnt_o    (ld_cnt[r]),
            .busy_o      (busy[r]),
            .underflow_o (underflow[r])
        );
    end

    // Hazard detection: only loads stall consumers, ALU results forward.
    always_comb begin
        hazard = 1'b0;
        if (bus.issue_use_rs && is_tracked(bus.issue_rs) && ld_cnt[bus.issue_rs] != '0) begin
            hazard = 1'b1;
        end
        if (bus.issue_use_rt && is_tracked(bus.issue_rt) && ld_cnt[bus.issue_rt] != '0) begin
            hazard = 1'b1;
        end
        if (bus.issue_wr && is_tracked(bus.issue_rd)) begin
            if (ld_cnt[bus.issue_rd] != '0 || pend_cnt[bus.issue_rd] == CNT_MAX) begin
                hazard = 1'b1;
            end
        end
        stall = bus.issue_valid && hazard;
        ack   = bus.issue_valid && !stall && !bus.flush;
    end

    // Per-register strobes; flush suppresses both issue and writeback.
    always_comb begin
        inc  = '0;
        dec  = '0;
        load = '0;
        for (int r = 1; r < NREG; r++) begin
            inc[r]  = ack && bus.issue_wr && (bus.issue_rd == AW'(r));
            load[r] = inc[r] && bus.issue_load;
            dec[r]  = bus.wb_valid && !bus.flush && (bus.wb_rd == AW'(r));
        end
    end

    // Sticky underflow flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (|underflow) begin
            err_q <= 1'b1;
        end
    end

    assign bus.stall         = stall;
    assign bus.issue_ack     = ack;
    assign bus.busy_mask     = busy;
    assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: driver pushes expected responses from
// a per-register count model, monitor pops and compares on the falling edge.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic reset;

    reg_scoreboard_if bus ();

    reg_scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              chk;
        bit              stall;
        bit              ack;
        logic [NREG-1:0] busy;
        bit              err;
    } exp_t;

    exp_t q[$];

    // Reference model: plain per-register counts.
    int m_pend[NREG];
    int m_ld[NREG];
    bit m_err;

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    cmp("stall", 32'(bus.stall), 32'(e.stall));
                    cmp("issue_ack", 32'(bus.issue_ack), 32'(e.ack));
                    cmp("busy_mask", 32'(bus.busy_mask), 32'(e.busy));
                    cmp("err_underflow", 32'(bus.err_underflow), 32'(e.err));
                end
            end
        end
    end

    // One cycle: drive inputs, predict outputs, advance the model on the edge.
    task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input bit wr, input int rd, input bit ld, input bit wbv, input int wbrd,
                        input bit fl, input bit rst, input bit chk);
        exp_t e;
        int   old[NREG];
        bit   st;
        bit   ak;
        bus.issue_valid  = v;
        bus.issue_rs     = rs[AW-1:0];
        bus.issue_rt     = rt[AW-1:0];
        bus.issue_use_rs = urs;
        bus.issue_use_rt = urt;
        bus.issue_wr     = wr;
        bus.issue_rd     = rd[AW-1:0];
        bus.issue_load   = ld;
        bus.wb_valid     = wbv;
        bus.wb_rd        = wbrd[AW-1:0];
        bus.flush        = fl;
        reset            = rst;

        st = v && ((urs && rs != 0 && m_ld[rs] != 0) ||
                   (urt && rt != 0 && m_ld[rt] != 0) ||
                   (wr && rd != 0 && (m_ld[rd] != 0 || m_pend[rd] >= 3)));
        ak = v && !st && !fl;
        e.chk   = chk;
        e.stall = st;
        e.ack   = ak;
        e.err   = m_err;
        for (int r = 0; r < NREG; r++) e.busy[r] = (m_pend[r] != 0);
        q.push_back(e);

        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_pend[r] = 0;
                m_ld[r]   = 0;
            end
            m_err = 0;
        end else if (fl) begin
            for (int r = 0; r < NREG; r++) begin
                m_pend[r] = 0;
                m_ld[r]   = 0;
            end
        end else begin
            old = m_pend;
            for (int r = 0; r < NREG; r++) if (m_ld[r] > 0) m_ld[r]--;
            if (ak && wr && rd != 0) begin
                m_pend[rd]++;
                if (ld) m_ld[rd] = LOAD_LAT;
            end
            if (wbv && wbrd != 0) begin
                if (old[wbrd] == 0) m_err = 1;
                if (m_pend[wbrd] > 0) m_pend[wbrd]--;
            end
        end
        #1;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Issue-only cycle.
    task automatic iss(input int rs, input int rt, input bit urs, input bit urt,
                       input bit wr, input int rd, input bit ld);
        step(1, rs, rt, urs, urt, wr, rd, ld, 0, 0, 0, 0, 1);
    endtask

    task automatic wb(input int rd);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, rd, 0, 0, 1);
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) begin
            m_pend[r] = 0;
            m_ld[r]   = 0;
        end
        m_err = 0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        // Reset from unknown state, then idle.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        nop(3);

        // Load rd=5, dependent add holds until the load result forwards.
        iss(0, 0, 0, 0, 1, 5, 1);
        iss(5, 0, 1, 0, 1, 6, 0);
        iss(5, 0, 1, 0, 1, 6, 0);
        iss(5, 0, 1, 0, 1, 6, 0);
        wb(5);
        wb(6);

        // ALU dependency never stalls.
        iss(0, 0, 0, 0, 1, 7, 0);
        iss(7, 7, 1, 1, 1, 8, 0);
        wb(7);
        wb(8);
        nop(1);

        // Counter full on rd=3, with a writeback in the stalled cycle.
        iss(0, 0, 0, 0, 1, 3, 0);
        iss(0, 0, 0, 0, 1, 3, 0);
        iss(0, 0, 0, 0, 1, 3, 0);
        step(1, 0, 0, 0, 0, 1, 3, 0, 1, 3, 0, 0, 1);
        iss(0, 0, 0, 0, 1, 3, 0);
        iss(0, 0, 0, 0, 1, 3, 0);
        wb(3);
        wb(3);
        wb(3);

        // Load then flush; flush also masks a valid issue.
        iss(0, 0, 0, 0, 1, 9, 1);
        step(1, 0, 0, 0, 0, 1, 10, 0, 1, 9, 1, 0, 1);
        iss(9, 9, 1, 1, 1, 11, 0);
        wb(11);

        // Underflow and register-zero traffic.
        wb(12);
        nop(2);
        wb(0);
        iss(0, 0, 1, 1, 1, 0, 1);
        iss(0, 0, 1, 1, 0, 0, 0);
        nop(2);

        // Reset in the middle of traffic.
        iss(0, 0, 0, 0, 1, 4, 1);
        step(1, 4, 0, 1, 0, 1, 2, 0, 0, 0, 0, 1, 1);
        iss(4, 0, 1, 0, 1, 4, 1);
        nop(2);

        // Randomized traffic on a small register window.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7,
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 7),
                 $urandom_range(0, 9) < 4,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0, 1);
        end
        nop(2);

        repeat (3) @(negedge clk);
        cmp("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Hazard controller that sequences access to the 32x32 register bank for the decode stage of the pipeline.
- Tracks in-flight writes to each register and the remaining load-use latency of each register.
- Asserts stall so decode holds any instruction whose source operand cannot yet be forwarded.
- Writeback retires entries; a pipeline flush squashes all tracking.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- AW, 5, register index width.
- CNT_W, 2, width of the per-register in-flight write counter (max 2^CNT_W-1 = 3).
- LOAD_LAT, 2, cycles after a load issue before its result is forwardable.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- issue_valid  in  1  decode presents an instruction.
- issue_rs  in  AW  source A index.
- issue_rt  in  AW  source B index.
- issue_use_rs  in  1  instruction reads rs (busA).
- issue_use_rt  in  1  instruction reads rt (busB).
- issue_wr  in  1  instruction writes a destination.
- issue_rd  in  AW  destination index.
- issue_load  in  1  instruction is a load (load_store class).
- wb_valid  in  1  writeback retires one write.
- wb_rd  in  AW  retired destination index.
- flush  in  1  squash all in-flight instructions.
- stall  out  1  combinational; decode must hold the instruction.
- issue_ack  out  1  combinational; equals issue_valid & ~stall & ~flush.
- busy_mask  out  NREG  registered; bit r = 1 when pend_cnt[r] != 0.
- err_underflow  out  1  registered, sticky; writeback retired a register with count 0.

Behaviour:
- State per register r in 1..NREG-1:
  - pend_cnt[r], CNT_W bits.
  - ld_cnt[r], 2 bits; remaining load latency.
- Register 0 is never tracked. Its counters and busy_mask bit read 0; issues and writebacks to r0 are ignored.
- Reset (synchronous, active-high): on the next edge all pend_cnt, ld_cnt, busy_mask and err_underflow become 0. Reset overrides every other input, mid-operation included.
- stall is 1 when issue_valid is 1 and any of the following holds:
  - issue_use_rs and rs != 0 and ld_cnt[rs] != 0 (load-use hazard);
  - issue_use_rt and rt != 0 and ld_cnt[rt] != 0;
  - issue_wr and rd != 0 and ld_cnt[rd] != 0 (WAW behind a load);
  - issue_wr and rd != 0 and pend_cnt[rd] == 3 (counter full).
- stall is 0 whenever issue_valid is 0.
- Issue (issue_ack = 1, issue_wr = 1, rd != 0):
  - pend_cnt[rd] increments;
  - if issue_load, ld_cnt[rd] loads LOAD_LAT.
- ld_cnt: every nonzero ld_cnt decrements by 1 each cycle, except in the cycle it is being loaded.
- Writeback (wb_valid = 1, wb_rd != 0):
  - pend_cnt[wb_rd] decrements;
  - if pend_cnt[wb_rd] is already 0, the count is unchanged and err_underflow sets.
- Issue and writeback to the same register in the same cycle: net pend_cnt change is 0. ld_cnt is still loaded if the issue is a load.
- Issue and writeback to different registers: both apply independently.
- flush (higher priority than issue and writeback, lower than reset):
  - issue_ack is forced 0;
  - next edge clears all pend_cnt and ld_cnt;
  - err_underflow keeps its value.
- Latency: busy_mask reflects an issue one cycle after issue_ack. ALU results are forwardable, so there is no stall on an ALU-only dependency.
- err_underflow clears only on reset.

Decomposition:
- Shared package holds:
  - NREG, AW, CNT_W, LOAD_LAT;
  - the constant REG_ZERO = 0;
  - instruction-class encodings shared with the register bank: load_store, alu_inm, branch, jump_abs, alu_reg, jump_rel, shift_var, shift.
- One natural sub-module, reg_track_entry: per-register pend_cnt/ld_cnt update logic, instantiated NREG-1 times. The top holds only stall and ack logic plus the error flag.

Test Plan:
- Reset, then idle 3 cycles -> busy_mask = 0, stall = 0, err_underflow = 0.
- Cycle 0: issue load rd=5. Cycle 1: issue add rs=5 -> stall = 1 in cycles 1 and 2, issue_ack in cycle 3; busy_mask[5] = 1 from cycle 1.
- Issue ALU rd=7, then ALU rs=7 next cycle -> no stall. wb_rd=7 -> busy_mask[7] returns to 0 one cycle later.
- Issue rd=3 three times, fourth issue rd=3 -> stall = 1. Same cycle with wb_rd=3 -> still stalls that cycle; next cycle the issue acks and pend_cnt[3] = 3.
- Issue load rd=9, flush in the next cycle -> busy_mask = 0 after one edge; an issue with rs=9 afterwards does not stall.
- wb_rd=12 with nothing pending -> err_underflow = 1 and stays 1 until reset. wb_rd=0 and issue_rd=0 never change state.
